// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage pipelined leading-zero / leading-sign counter with
// a normalising left shift. One operand is accepted per cycle on a
// valid/ready interface.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         synchronous clear of both pipeline stages
//   in_valid/in_ready, in_data, in_mode, in_tag
//                 operand input; in_mode 0 = leading zeros, 1 = leading sign bits
//   out_valid/out_ready, out_count, out_zero, out_norm, out_tag
//                 result output, driven straight from the stage-2 registers
module lzc_norm_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LVL = $clog2(WIDTH);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_mode;
  logic [TAG_W-1:0] s1_tag;
  logic [CW-1:0]    s1_count;
  logic             s1_zero;
  logic             s2_valid;
  logic             s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // Sign mode is reduced to a leading-zero count: XOR with the sign bit turns
  // every leading copy of the sign into a zero, and the MSB itself always
  // becomes zero, so the count includes it.
  logic [WIDTH-1:0] scan;
  logic [CW-1:0]    node_cnt [LVL+1][WIDTH];
  logic             node_vld [LVL+1][WIDTH];
  logic [CW-1:0]    in_count;
  logic             in_zero;

  always_comb begin
    scan = in_mode ? (in_data ^ {WIDTH{in_data[WIDTH-1]}}) : in_data;
    for (int l = 0; l <= LVL; l++) begin
      for (int j = 0; j < WIDTH; j++) begin
        node_cnt[l][j] = '0;
        node_vld[l][j] = 1'b0;
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      node_vld[0][j] = scan[j];
    end
    // Merge cell: a node covering 2^l bits is valid if either half holds a
    // one; the upper half wins when valid, otherwise the lower half's count is
    // offset by the full width of the upper half.
    for (int l = 1; l <= LVL; l++) begin
      for (int j = 0; j < (WIDTH >> l); j++) begin
        node_vld[l][j] = node_vld[l-1][2*j+1] | node_vld[l-1][2*j];
        node_cnt[l][j] = node_vld[l-1][2*j+1] ? node_cnt[l-1][2*j+1]
                                              : CW'(1 << (l-1)) + node_cnt[l-1][2*j];
      end
    end
    in_count = node_vld[LVL][0] ? node_cnt[LVL][0] : CW'(WIDTH);
    in_zero  = (in_data == '0);
  end

  // Sign mode keeps one sign bit, so it shifts by count-1. A zero operand in
  // LZ mode has count == WIDTH, which wraps to a shift of 0; the result is
  // still zero.
  logic [LVL-1:0]   shamt;
  logic [WIDTH-1:0] sh [LVL+1];

  always_comb begin
    shamt = LVL'(s1_mode ? (s1_count - CW'(1)) : s1_count);
    sh[0] = s1_data;
    for (int k = 0; k < LVL; k++) begin
      sh[k+1] = shamt[k] ? (sh[k] << (1 << k)) : sh[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= 1'b0;
      s1_tag    <= '0;
      s1_count  <= '0;
      s1_zero   <= 1'b0;
      s2_valid  <= 1'b0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_count <= s1_count;
          out_zero  <= s1_zero;
          out_norm  <= sh[LVL];
          out_tag   <= s1_tag;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data  <= in_data;
          s1_mode  <= in_mode;
          s1_tag   <= in_tag;
          s1_count <= in_count;
          s1_zero  <= in_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
module tb_lzc_norm_pipe;
  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int CWT = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           in_mode = 1'b0;
  logic [TW-1:0]  in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [CWT-1:0] out_count;
  logic           out_zero;
  logic [W-1:0]   out_norm;
  logic [TW-1:0]  out_tag;

  lzc_norm_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_zero(out_zero), .out_norm(out_norm), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CWT-1:0] count;
    logic           zero;
    logic [W-1:0]   norm;
    logic [TW-1:0]  tag;
  } exp_t;

  typedef struct {
    logic [W-1:0]   d;
    logic           m;
    logic [TW-1:0]  t;
    logic [CWT-1:0] c;
    logic           z;
    logic [W-1:0]   n;
  } vec_t;

  exp_t sb[$];
  logic last_acc_in = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk from the MSB counting bits per the mode rule.
  function automatic exp_t model(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t);
    exp_t e;
    int n;
    n = 0;
    if (m) while (n < W && d[W-1-n] == d[W-1]) n++;
    else   while (n < W && d[W-1-n] == 1'b0) n++;
    e.count = CWT'(n);
    e.zero  = (d == '0);
    e.tag   = t;
    if (m)           e.norm = d << (n - 1);
    else if (n == W) e.norm = '0;
    else             e.norm = d << n;
    return e;
  endfunction

  // One clock: sample handshakes at the falling edge, advance, look 1ns after.
  task automatic tick();
    logic           acc_out, stalled;
    logic [W-1:0]   s_norm;
    logic [TW-1:0]  s_tag;
    logic [CWT-1:0] s_count;
    exp_t           e;
    @(negedge clk);
    stalled = out_valid && !out_ready && !flush;
    s_norm  = out_norm;
    s_tag   = out_tag;
    s_count = out_count;
    acc_out = out_valid && out_ready && !flush;
    last_acc_in = in_valid && in_ready && !flush;
    if (flush) sb.delete();
    if (acc_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got output tag %0h expected no output at %0t", out_tag, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_count", out_count, e.count);
        chk("sb_zero",  out_zero,  e.zero);
        chk("sb_norm",  out_norm,  e.norm);
        chk("sb_tag",   out_tag,   e.tag);
      end
    end
    if (last_acc_in) sb.push_back(model(in_data, in_mode, in_tag));
    @(posedge clk);
    #1;
    if (stalled) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_norm",  out_norm,  s_norm);
      chk("hold_tag",   out_tag,   s_tag);
      chk("hold_count", out_count, s_count);
    end
  endtask

  task automatic feed(input int k);
    in_valid = (k < 5);
    in_data  = $urandom;
    in_mode  = k[0];
    in_tag   = TW'(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    int   sent;
    vt[0]  = '{32'h0001_0000, 1'b0, 4'd3,  6'd15, 1'b0, 32'h8000_0000};
    vt[1]  = '{32'h0000_0000, 1'b0, 4'd1,  6'd32, 1'b1, 32'h0000_0000};
    vt[2]  = '{32'h0000_0000, 1'b1, 4'd2,  6'd32, 1'b1, 32'h0000_0000};
    vt[3]  = '{32'hFFFF_F000, 1'b1, 4'd4,  6'd20, 1'b0, 32'h8000_0000};
    vt[4]  = '{32'h0000_00FF, 1'b1, 4'd5,  6'd24, 1'b0, 32'h7F80_0000};
    vt[5]  = '{32'h4000_0000, 1'b1, 4'd6,  6'd1,  1'b0, 32'h4000_0000};
    vt[6]  = '{32'hFFFF_FFFF, 1'b1, 4'd7,  6'd32, 1'b0, 32'h8000_0000};
    vt[7]  = '{32'h8000_0000, 1'b0, 4'd8,  6'd0,  1'b0, 32'h8000_0000};
    vt[8]  = '{32'h0000_0001, 1'b0, 4'd9,  6'd31, 1'b0, 32'h8000_0000};
    vt[9]  = '{32'h0000_0001, 1'b1, 4'd10, 6'd31, 1'b0, 32'h4000_0000};
    vt[10] = '{32'hFFFF_FFFF, 1'b0, 4'd11, 6'd0,  1'b0, 32'hFFFF_FFFF};
    vt[11] = '{32'h0000_0F00, 1'b0, 4'd12, 6'd20, 1'b0, 32'hF000_0000};

    // Reset
    #3;
    chk("rst_out_valid", out_valid, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid2", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_norm",  out_norm,  0);

    // Directed vectors, one at a time, checking the two-edge latency
    out_ready = 1'b1;
    foreach (vt[i]) begin
      in_valid = 1'b1; in_data = vt[i].d; in_mode = vt[i].m; in_tag = vt[i].t;
      tick();
      in_valid = 1'b0;
      chk("vec_early_valid", out_valid, 0);
      tick();
      chk("vec_valid", out_valid, 1);
      chk("vec_count", out_count, vt[i].c);
      chk("vec_zero",  out_zero,  vt[i].z);
      chk("vec_norm",  out_norm,  vt[i].n);
      chk("vec_tag",   out_tag,   vt[i].t);
      tick();
    end

    // Backpressure: 5 operands, consumer stalled for 4 cycles
    out_ready = 1'b0;
    sent = 0;
    feed(sent);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (last_acc_in) begin sent++; feed(sent); end
      if (c == 1) chk("bp_in_ready_low", in_ready, 0);
    end
    chk("bp_accepts", sent, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_tag_order", out_tag, k);
      tick();
      if (last_acc_in) begin sent++; feed(sent); end
    end
    chk("bp_drained", out_valid, 0);
    in_valid = 1'b0;

    // Flush with two in flight and a simultaneous input
    in_valid = 1'b1; in_data = 32'h0000_1234; in_mode = 1'b0; in_tag = 4'd1;
    tick();
    in_data = 32'hFF00_0000; in_mode = 1'b1; in_tag = 4'd2;
    tick();
    flush = 1'b1; in_data = 32'h0000_0003; in_mode = 1'b0; in_tag = 4'd9;
    chk("flush_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid0", out_valid, 0);
    tick();
    chk("flush_out_valid1", out_valid, 0);
    tick();
    chk("flush_out_valid2", out_valid, 0);
    in_valid = 1'b1; in_data = 32'h0000_0100; in_mode = 1'b0; in_tag = 4'd13;
    tick();
    in_valid = 1'b0;
    chk("post_flush_early", out_valid, 0);
    tick();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_tag",   out_tag,   13);
    chk("post_flush_count", out_count, 23);
    tick();

    // Asynchronous reset between edges
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00F0_0000; in_mode = 1'b0; in_tag = 4'd5;
    tick();
    in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_count", out_count, 0);
    chk("areset_zero",  out_zero,  0);
    chk("areset_norm",  out_norm,  0);
    chk("areset_tag",   out_tag,   0);
    sb.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("post_reset_no_stale", out_valid, 0);
      tick();
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] d;
      d = $urandom;
      d = d >> $urandom_range(0, 32);
      if ($urandom_range(0, 1) == 1) d = ~d;
      if ($urandom_range(0, 19) == 0) d = '0;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d;
      in_mode   = $urandom_range(0, 1) == 1;
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) tick();
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
Parametrised, pipelined leading-zero / leading-sign counter with an integrated normalising left shift, for the floating-point datapath after add/sub and int-to-float conversion. Accepts one WIDTH-bit operand per cycle on a valid/ready interface. Returns, two stages later, the count, an all-zero flag and the normalised operand. A mode bit selects count-leading-zeros or count-leading-sign-bits (two's complement).

Parameters:
WIDTH, 32, operand width; power of two, 8..64
TAG_W, 4, width of opaque sideband tag carried alongside each operand
CW, $clog2(WIDTH)+1, count width (derived, not overridable); holds 0..WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline clear
in_valid  input  1  operand valid
in_ready  output  1  block can accept operand this cycle
in_data  input  WIDTH  operand
in_mode  input  1  0 = leading zeros, 1 = leading sign bits
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_count  output  CW  count per mode
out_zero  output  1  operand was all zeros
out_norm  output  WIDTH  normalised operand
out_tag  output  TAG_W  tag of this result

Behaviour:
- One clock, one reset. Reset is asynchronous and active-low. All registers clear immediately on rst_n low: s1_valid = s2_valid = 0; out_valid = 0; out_count = 0; out_zero = 0; out_norm = 0; out_tag = 0. in_ready is 1 once reset is released.
- Two register stages.
  - S1 captures data, mode and tag, and computes the count from a tree of 2:1 merge cells: per half, a valid bit and a sub-count; the upper half wins when valid.
  - S2 applies the shift and holds the outputs. Outputs are driven directly from S2 registers.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_adv. This is combinational, with no in_valid dependency.
  - Throughput is 1 per cycle when out_ready is held high.
  - Latency: operand accepted at edge N; result on outputs with out_valid=1 after edge N+1.
- Results are held stable while out_valid && !out_ready. No drop, no duplication, order preserved.
- Mode 0 (LZ):
  - count = number of leading zeros, 0..WIDTH.
  - norm = data << count when count < WIDTH; norm = 0 when all zero (count = WIDTH).
- Mode 1 (sign):
  - count = number of leading bits equal to data[WIDTH-1], including the MSB, 1..WIDTH.
  - norm = data << (count-1), so the sign bit occupies bit WIDTH-1 and one sign bit is retained.
  - All-ones input gives count=WIDTH, norm = 1 followed by zeros. All-zeros input gives count=WIDTH, norm=0.
- out_zero = 1 iff the operand was all zeros, independent of mode.
- Shifter: logarithmic, $clog2(WIDTH) levels; zeros shifted in.
- flush:
  - On the next edge, s1_valid and s2_valid clear. Data registers are don't-care.
  - An input presented in a flush cycle is discarded even if in_ready=1.
  - flush takes priority over all transfers in that cycle.
- Reset mid-operation: in-flight operands are lost. No output is emitted for them after reset release.
- Mode and tag are per operand. Mixed-mode back-to-back streams are legal.

Test Plan:
- Reset and basic LZ: after reset, check out_valid=0 and in_ready=1. Then WIDTH=32, mode 0, data 0x0001_0000, tag 3 -> two edges later out_count=15, out_norm=0x8000_0000, out_zero=0, out_tag=3.
- Zero operand: data 0x0000_0000 in mode 0 and then mode 1 -> both give out_count=32, out_zero=1, out_norm=0.
- Sign mode: 0xFFFF_F000 -> count=20, norm=0x8000_0000. 0x0000_00FF -> count=24, norm=0x7F80_0000. 0x4000_0000 -> count=1, norm=0x4000_0000. 0xFFFF_FFFF -> count=32, norm=0x8000_0000.
- Backpressure: stream 5 operands with tags 0..4, out_ready=0 for 4 cycles.
  - in_ready falls after 2 accepts.
  - outputs stay stable while stalled.
  - after out_ready rises, tags emerge 0..4 with no gaps or repeats and correct counts; full rate with no bubbles after release.
- Flush: 2 operands in flight, flush=1 for one cycle together with in_valid -> no out_valid afterwards and the flush-cycle input is discarded. The next operand after flush returns normally with 2-cycle latency.
- Async reset mid-stream: pull rst_n low between edges -> outputs clear immediately without a clock edge. After release, no stale results appear.
